// File: rtl/jolt160_mem_responder.sv
// rtl/jolt160_mem_responder.sv - Jolt160 data-bus memory responder with wait states
// Byte-addressable 16-bit RAM behind a req/data_ready handshake.
module jolt160_mem_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_rdwr,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  data_acc_sz,
  input  logic                  data_inout_we,
  input  logic [15:0]           write_data_in,
  output logic [15:0]           read_data_out,
  output logic                  data_ready,
  output logic                  busy,
  output logic                  misalign_err
);

  localparam int         DEPTH     = 2 ** (ADDR_WIDTH - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);
  localparam logic       WAIT_EN   = (WAIT_STATES > 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_sz;
  logic                  r_we;
  logic [15:0]           r_wdata;
  logic [15:0]           r_mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_sz;
  logic                  w_we;
  logic [15:0]           w_wdata;
  logic [ADDR_WIDTH-2:0] w_word;
  logic                  w_odd;
  logic                  w_misalign;
  logic [15:0]           w_rword;
  logic [15:0]           w_rdata;
  logic [15:0]           w_wword;
  logic                  w_wen;

  assign w_accept     = (r_state == S_IDLE) && req_rdwr;
  assign w_enter_resp = (w_accept && !WAIT_EN) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With zero wait states the access happens on the accept edge, so use live inputs.
  assign w_addr  = (r_state == S_IDLE) ? addr_in       : r_addr;
  assign w_sz    = (r_state == S_IDLE) ? data_acc_sz   : r_sz;
  assign w_we    = (r_state == S_IDLE) ? data_inout_we : r_we;
  assign w_wdata = (r_state == S_IDLE) ? write_data_in : r_wdata;

  assign w_word     = w_addr[ADDR_WIDTH-1:1];
  assign w_odd      = w_addr[0];
  assign w_misalign = w_sz && w_odd;
  assign w_rword    = r_mem[w_word];

  always_comb begin
    w_rdata = 16'h0000;
    w_wword = w_rword;
    w_wen   = 1'b0;
    if (w_we) begin
      if (!w_sz) begin
        w_wen = 1'b1;
        if (w_odd) w_wword[15:8] = w_wdata[7:0];
        else       w_wword[7:0]  = w_wdata[7:0];
      end else if (!w_odd) begin
        w_wen   = 1'b1;
        w_wword = w_wdata;
      end
    end else begin
      if (!w_sz)       w_rdata = w_odd ? {8'h00, w_rword[15:8]} : {8'h00, w_rword[7:0]};
      else if (!w_odd) w_rdata = w_rword;
    end
  end

  // RAM is never cleared; the reset gate only blocks a write on an edge held in reset.
  always_ff @(posedge clk) begin
    if (reset && w_enter_resp && w_wen) r_mem[w_word] <= w_wword;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_addr        <= '0;
      r_sz          <= 1'b0;
      r_we          <= 1'b0;
      r_wdata       <= 16'h0000;
      read_data_out <= 16'h0000;
      data_ready    <= 1'b0;
      busy          <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      data_ready   <= w_enter_resp;
      misalign_err <= w_enter_resp && w_misalign;
      if (w_enter_resp) read_data_out <= w_rdata;
      case (r_state)
        S_IDLE: begin
          if (req_rdwr) begin
            r_addr  <= addr_in;
            r_sz    <= data_acc_sz;
            r_we    <= data_inout_we;
            r_wdata <= write_data_in;
            busy    <= 1'b1;
            if (WAIT_EN) begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_LOAD;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP: begin
          if (req_rdwr) begin
            r_state <= S_HOLD;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!req_rdwr) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
